// File: rtl/mero_cpu_top.sv
// Multi-cycle RV32I core with a single merged instruction/data memory port.
// Every instruction is fetched, then executed in one cycle. Loads and stores
// take an extra memory phase. Any exception parks the core in a terminal
// TRAP state with trap_o held high until reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | raise rd at addr=pc, latch the instruction when ready is seen
// S_EXEC  | decode, ALU, branch/jump resolution, exception detection
// S_MEM   | hold a load/store request until ready, write back the load
// S_TRAP  | terminal halt, no bus requests, pc frozen

module mero_cpu_top #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        trap_o,
  input  logic        merged_mem_ready_i,
  input  logic [31:0] merged_mem_data_i,
  output logic        merged_mem_rd_o,
  output logic        merged_mem_wr_o,
  output logic [31:0] merged_mem_addr_o,
  output logic [31:0] merged_mem_data_o,
  output logic [3:0]  byte_select_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rf [1:31];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] pc_plus4;

  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign funct7  = ir[31:25];
  assign rd_idx  = ir[11:7];
  assign rs1_idx = ir[19:15];
  assign rs2_idx = ir[24:20];
  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf[rs2_idx];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic        sub_op;
  logic [31:0] alu_res;

  // Shared ALU for register-register and register-immediate forms
  always_comb begin
    alu_b  = (opcode == OP_OP) ? rs2_val : imm_i;
    shamt  = (opcode == OP_OP) ? rs2_val[4:0] : rs2_idx;
    sub_op = (opcode == OP_OP) && funct7[5];
    case (funct3)
      3'b000:  alu_res = sub_op ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_res = rs1_val << shamt;
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val < alu_b};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b101:  alu_res = funct7[5] ? $unsigned($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      3'b110:  alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  logic        illegal;
  logic        wb_en;
  logic [31:0] wb_val;
  logic [31:0] next_pc;
  logic        is_load;
  logic        is_store;
  logic        br_taken;

  // Instruction classification, write-back value and next pc
  always_comb begin
    illegal  = 1'b0;
    wb_en    = 1'b0;
    wb_val   = alu_res;
    next_pc  = pc_plus4;
    is_load  = 1'b0;
    is_store = 1'b0;
    br_taken = 1'b0;
    case (opcode)
      OP_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OP_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        wb_en   = 1'b1;
        wb_val  = pc_plus4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
        illegal = (funct3 != 3'b000);
      end
      OP_BRANCH: begin
        case (funct3)
          3'b000:  br_taken = (rs1_val == rs2_val);
          3'b001:  br_taken = (rs1_val != rs2_val);
          3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
          3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  br_taken = (rs1_val < rs2_val);
          3'b111:  br_taken = (rs1_val >= rs2_val);
          default: illegal  = 1'b1;
        endcase
        if (br_taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        is_load = 1'b1;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        is_store = 1'b1;
        illegal  = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_IMM: begin
        wb_en   = 1'b1;
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OP_OP: begin
        wb_en   = 1'b1;
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_FENCE: illegal = (funct3 != 3'b000);
      default:  illegal = 1'b1;
    endcase
  end

  logic [31:0] mem_addr_c;
  logic        misalign;
  logic [3:0]  lane_bs;
  logic [31:0] lane_wdata;
  logic        exc;

  // Effective address, lane steering and exception summary
  always_comb begin
    mem_addr_c = rs1_val + (is_store ? imm_s : imm_i);
    misalign   = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        lane_bs    = 4'b0001 << mem_addr_c[1:0];
        lane_wdata = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        lane_bs    = 4'b0011 << mem_addr_c[1:0];
        lane_wdata = {2{rs2_val[15:0]}};
        misalign   = mem_addr_c[0];
      end
      default: begin
        lane_bs    = 4'b1111;
        lane_wdata = rs2_val;
        misalign   = (mem_addr_c[1:0] != 2'b00);
      end
    endcase
    exc = illegal || ((is_load || is_store) && misalign) || (next_pc[1:0] != 2'b00);
  end

  logic [31:0] ld_word;
  logic [31:0] load_val;

  // Extract and extend the addressed lane(s) from the returned word
  always_comb begin
    ld_word = merged_mem_data_i >> {merged_mem_addr_o[1:0], 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  load_val = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  load_val = {24'd0, ld_word[7:0]};
      3'b101:  load_val = {16'd0, ld_word[15:0]};
      default: load_val = ld_word;
    endcase
  end

  // Sequencer: bus requests, register file write-back, pc and trap flag
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state             <= S_FETCH;
      pc                <= RESET_ADDR;
      trap_o            <= 1'b0;
      merged_mem_rd_o   <= 1'b0;
      merged_mem_wr_o   <= 1'b0;
      merged_mem_addr_o <= 32'd0;
      merged_mem_data_o <= 32'd0;
      byte_select_o     <= 4'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!merged_mem_rd_o) begin
            merged_mem_rd_o   <= 1'b1;
            merged_mem_addr_o <= pc;
            byte_select_o     <= 4'b1111;
          end else if (merged_mem_ready_i) begin
            ir              <= merged_mem_data_i;
            merged_mem_rd_o <= 1'b0;
            state           <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exc) begin
            trap_o <= 1'b1;
            state  <= S_TRAP;
          end else if (is_load || is_store) begin
            merged_mem_rd_o   <= is_load;
            merged_mem_wr_o   <= is_store;
            merged_mem_addr_o <= mem_addr_c;
            merged_mem_data_o <= lane_wdata;
            byte_select_o     <= lane_bs;
            state             <= S_MEM;
          end else begin
            if (wb_en && (rd_idx != 5'd0)) rf[rd_idx] <= wb_val;
            pc    <= next_pc;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (merged_mem_ready_i) begin
            if (merged_mem_rd_o && (rd_idx != 5'd0)) rf[rd_idx] <= load_val;
            merged_mem_rd_o <= 1'b0;
            merged_mem_wr_o <= 1'b0;
            pc              <= pc_plus4;
            state           <= S_FETCH;
          end
        end
        default: begin
          trap_o          <= 1'b1;
          merged_mem_rd_o <= 1'b0;
          merged_mem_wr_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mero_cpu_top.sv
// Directed bench for mero_cpu_top: a byte-lane RAM model with programmable
// wait states, small hand-assembled programs, results read back from RAM.
module tb_mero_cpu_top;

  logic        clk;
  logic        rst;
  logic        trap;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bs;

  mero_cpu_top #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .trap_o             (trap),
    .merged_mem_ready_i (mem_ready),
    .merged_mem_data_i  (mem_rdata),
    .merged_mem_rd_o    (mem_rd),
    .merged_mem_wr_o    (mem_wr),
    .merged_mem_addr_o  (mem_addr),
    .merged_mem_data_o  (mem_wdata),
    .byte_select_o      (mem_bs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } wr_t;

  logic [31:0] mem [0:255];
  logic [31:0] rd_log [$];
  wr_t         wr_log [$];
  logic [31:0] prog [$];
  int unsigned wait_states;
  int unsigned req_cnt;
  logic        mem_clr;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int errors;
  int checks;

  assign mem_ready = (mem_rd || mem_wr) && (req_cnt >= wait_states);
  assign mem_rdata = mem[mem_addr[9:2]];

  // RAM model: program loading, lane writes, access logging, wait-state counter
  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_ready) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      rd_log.delete();
      wr_log.delete();
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else begin
      if (mem_wr && mem_ready) begin
        for (int k = 0; k < 4; k++)
          if (mem_bs[k]) mem[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        wr_log.push_back({mem_addr, mem_wdata, mem_bs});
      end
      if (mem_rd && mem_ready) rd_log.push_back(mem_addr);
    end
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input int imm, input int rd, input int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset, clear RAM and logs, load prog[] from address 0, then release.
  task automatic load_and_start(input int unsigned ws);
    rst = 1'b0;
    wait_states = ws;
    @(posedge clk); #1;
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      ld_en = 1'b1;
      ld_addr = 8'(i);
      ld_data = prog[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic wait_trap(input string tag, input int maxc);
    int n;
    int busy;
    n = 0;
    while (!trap && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_trap"}, 32'(trap), 32'd1);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_rd || mem_wr) busy++;
    end
    chk({tag, "_quiet_after_trap"}, busy, 0);
    chk({tag, "_trap_sticky"}, 32'(trap), 32'd1);
  endtask

  logic [31:0] exp_p1 [0:8];
  logic [31:0] exp_p2 [0:4];
  logic [31:0] exp_p3 [0:8];
  int n;

  initial begin
    clk = 1'b0; rst = 1'b0; mem_clr = 1'b0; ld_en = 1'b0;
    ld_addr = '0; ld_data = '0; wait_states = 0;
    errors = 0; checks = 0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_bs", 32'(mem_bs), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    // ALU chain, run with 3 wait states on every access
    prog.delete();
    prog.push_back(enc_i(5, 0, 0, 1, 7'h13));       // 00 addi x1,x0,5
    prog.push_back(enc_i(-7, 1, 0, 2, 7'h13));      // 04 addi x2,x1,-7
    prog.push_back(enc_r(0, 2, 1, 3, 3));           // 08 sltu x3,x1,x2
    prog.push_back(enc_r(7'h20, 1, 2, 5, 4));       // 0c sra  x4,x2,x1
    prog.push_back(enc_r(0, 1, 2, 2, 5));           // 10 slt  x5,x2,x1
    prog.push_back(enc_r(0, 1, 2, 5, 6));           // 14 srl  x6,x2,x1
    prog.push_back(enc_r(7'h20, 2, 1, 0, 7));       // 18 sub  x7,x1,x2
    prog.push_back(enc_u(32'h12345, 8, 7'h37));     // 1c lui  x8,0x12345
    prog.push_back(enc_u(1, 9, 7'h17));             // 20 auipc x9,1
    prog.push_back(enc_i(-1, 1, 4, 10, 7'h13));     // 24 xori x10,x1,-1
    prog.push_back(32'h0000_000F);                  // 28 fence
    for (int k = 0; k < 9; k++)
      prog.push_back(enc_s(32'h200 + 4*k, 2 + k, 0, 2)); // 2c.. sw x(2+k)
    prog.push_back(32'h0000_0073);                  // 50 ecall
    exp_p1[0] = 32'hFFFF_FFFE; exp_p1[1] = 32'h0000_0001; exp_p1[2] = 32'hFFFF_FFFF;
    exp_p1[3] = 32'h0000_0001; exp_p1[4] = 32'h07FF_FFFF; exp_p1[5] = 32'h0000_0007;
    exp_p1[6] = 32'h1234_5000; exp_p1[7] = 32'h0000_1020; exp_p1[8] = 32'hFFFF_FFFA;
    load_and_start(3);
    n = 0;
    while (!mem_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch0_addr", mem_addr, 32'd0);
    chk("fetch0_bs", 32'(mem_bs), 32'hF);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wait%0d_rd", k), 32'(mem_rd), 32'd1);
      chk($sformatf("wait%0d_addr", k), mem_addr, 32'd0);
      chk($sformatf("wait%0d_ready", k), 32'(mem_ready), 32'd0);
      @(negedge clk);
    end
    chk("wait_ready_high", 32'(mem_ready), 32'd1);
    chk("wait_rd_held", 32'(mem_rd), 32'd1);
    @(negedge clk);
    chk("fetch0_rd_dropped", 32'(mem_rd), 32'd0);
    wait_trap("alu", 3000);
    for (int k = 0; k < 9; k++)
      chk($sformatf("alu_x%0d", k + 2), mem[(32'h200 >> 2) + k], exp_p1[k]);

    // Byte and halfword stores/loads, single-cycle RAM
    prog.delete();
    prog.push_back(enc_i(32'h80, 0, 0, 5, 7'h13));  // 00 addi x5,x0,0x80
    prog.push_back(enc_i(32'h100, 0, 0, 6, 7'h13)); // 04 addi x6,x0,0x100
    prog.push_back(enc_s(3, 5, 6, 0));              // 08 sb  x5,3(x6)
    prog.push_back(enc_i(3, 6, 0, 7, 7'h03));       // 0c lb  x7,3(x6)
    prog.push_back(enc_i(3, 6, 4, 8, 7'h03));       // 10 lbu x8,3(x6)
    prog.push_back(enc_u(8, 10, 7'h37));            // 14 lui x10,0x8
    prog.push_back(enc_i(32'h7F, 10, 0, 10, 7'h13));// 18 addi x10,x10,0x7f
    prog.push_back(enc_s(2, 10, 6, 1));             // 1c sh  x10,2(x6)
    prog.push_back(enc_i(2, 6, 1, 11, 7'h03));      // 20 lh  x11,2(x6)
    prog.push_back(enc_i(2, 6, 5, 12, 7'h03));      // 24 lhu x12,2(x6)
    prog.push_back(enc_i(0, 6, 2, 13, 7'h03));      // 28 lw  x13,0(x6)
    prog.push_back(enc_s(32'h200, 7, 0, 2));        // 2c sw x7
    prog.push_back(enc_s(32'h204, 8, 0, 2));        // 30 sw x8
    prog.push_back(enc_s(32'h208, 11, 0, 2));       // 34 sw x11
    prog.push_back(enc_s(32'h20C, 12, 0, 2));       // 38 sw x12
    prog.push_back(enc_s(32'h210, 13, 0, 2));       // 3c sw x13
    prog.push_back(32'h0000_0073);                  // 40 ecall
    exp_p2[0] = 32'hFFFF_FF80; exp_p2[1] = 32'h0000_0080; exp_p2[2] = 32'hFFFF_807F;
    exp_p2[3] = 32'h0000_807F; exp_p2[4] = 32'h807F_0000;
    load_and_start(0);
    wait_trap("lanes", 3000);
    chk("lanes_nwrites", wr_log.size(), 7);
    chk("sb_addr", wr_log[0].a, 32'h0000_0103);
    chk("sb_bs", 32'(wr_log[0].b), 32'h8);
    chk("sb_data", wr_log[0].d, 32'h8080_8080);
    chk("sh_addr", wr_log[1].a, 32'h0000_0102);
    chk("sh_bs", 32'(wr_log[1].b), 32'hC);
    chk("sh_data", wr_log[1].d, 32'h807F_807F);
    for (int k = 0; k < 5; k++)
      chk($sformatf("lanes_res%0d", k), mem[(32'h200 >> 2) + k], exp_p2[k]);

    // Branches and jumps: fetch order and link values
    prog.delete();
    prog.push_back(enc_i(7, 0, 0, 3, 7'h13));       // 00 addi x3,x0,7
    prog.push_back(enc_b(8, 0, 0, 0));              // 04 beq x0,x0,+8
    prog.push_back(enc_i(1, 0, 0, 3, 7'h13));       // 08 addi x3,x0,1 (skipped)
    prog.push_back(enc_j(12, 1));                   // 0c jal x1,+12
    prog.push_back(enc_i(2, 0, 0, 3, 7'h13));       // 10 (skipped)
    prog.push_back(enc_i(3, 0, 0, 3, 7'h13));       // 14 (skipped)
    prog.push_back(enc_b(8, 0, 0, 1));              // 18 bne x0,x0,+8 (not taken)
    prog.push_back(enc_s(32'h200, 1, 0, 2));        // 1c sw x1
    prog.push_back(enc_s(32'h204, 3, 0, 2));        // 20 sw x3
    prog.push_back(enc_i(32'h2C, 0, 0, 5, 7'h67));  // 24 jalr x5,0x2c(x0)
    prog.push_back(enc_i(4, 0, 0, 3, 7'h13));       // 28 (skipped)
    prog.push_back(enc_s(32'h208, 5, 0, 2));        // 2c sw x5
    prog.push_back(32'h0000_0073);                  // 30 ecall
    exp_p3[0] = 32'h00; exp_p3[1] = 32'h04; exp_p3[2] = 32'h0C; exp_p3[3] = 32'h18;
    exp_p3[4] = 32'h1C; exp_p3[5] = 32'h20; exp_p3[6] = 32'h24; exp_p3[7] = 32'h2C;
    exp_p3[8] = 32'h30;
    load_and_start(0);
    wait_trap("flow", 3000);
    chk("flow_nreads", rd_log.size(), 9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("flow_fetch%0d", k), rd_log[k], exp_p3[k]);
    chk("flow_jal_link", mem[32'h200 >> 2], 32'h0000_0010);
    chk("flow_x3", mem[32'h204 >> 2], 32'h0000_0007);
    chk("flow_jalr_link", mem[32'h208 >> 2], 32'h0000_0028);

    // Illegal all-zero instruction
    prog.delete();
    prog.push_back(enc_i(1, 0, 0, 1, 7'h13));       // 00 addi x1,x0,1
    prog.push_back(32'h0000_0000);                  // 04 illegal
    load_and_start(0);
    wait_trap("illegal", 500);
    chk("illegal_nreads", rd_log.size(), 2);
    chk("illegal_nwrites", wr_log.size(), 0);

    // Misaligned word load: trap before any bus access
    prog.delete();
    prog.push_back(enc_i(32'h100, 0, 0, 6, 7'h13)); // 00 addi x6,x0,0x100
    prog.push_back(enc_i(2, 6, 2, 7, 7'h03));       // 04 lw x7,2(x6)
    load_and_start(0);
    wait_trap("misalign_lw", 500);
    chk("misalign_lw_nreads", rd_log.size(), 2);
    chk("misalign_lw_nwrites", wr_log.size(), 0);

    // Misaligned jump target
    prog.delete();
    prog.push_back(enc_i(6, 0, 0, 1, 7'h13));       // 00 addi x1,x0,6
    prog.push_back(enc_i(0, 1, 0, 0, 7'h67));       // 04 jalr x0,0(x1)
    load_and_start(0);
    wait_trap("misalign_jalr", 500);
    chk("misalign_jalr_nreads", rd_log.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mero_cpu_top.md
Name: mero_cpu_top

Overview:
- Multi-cycle RV32I integer core (no CSRs, no interrupts) with one merged instruction/data memory port.
- Sits at the top of the CPU subsystem. Drives a word-addressed RAM wrapper through a rd/wr/ready handshake with byte lanes.
- Halts and raises trap_o on any exception.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- trap_o  out  1  sticky halt flag; high once an exception occurs.
- merged_mem_ready_i  in  1  memory completes the current access this cycle.
- merged_mem_data_i  in  32  read data; valid when ready is high.
- merged_mem_rd_o  out  1  read request.
- merged_mem_wr_o  out  1  write request.
- merged_mem_addr_o  out  32  byte address. The RAM decodes bits [16:2].
- merged_mem_data_o  out  32  write data, already lane-aligned.
- byte_select_o  out  4  byte-lane enables; bit n selects bits [8n+7:8n].

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - PC=RESET_ADDR, state=FETCH.
  - trap_o=0, rd=0, wr=0, byte_select=0, addr=0, data_o=0.
  - Register file contents are not reset.
  - Reset mid-access abandons the access; there is no write-back.
- Register file: x1..x31, 32 bits each. x0 reads 0 and ignores writes.
- Memory handshake:
  - The core asserts rd or wr (never both) with a stable addr, data_o and byte_select.
  - It holds all four until it samples merged_mem_ready_i=1 at a rising edge.
  - Read data is captured in that same cycle. rd/wr deassert the following cycle.
  - Ready is ignored when no request is pending.
  - Any number of wait cycles is allowed; the RAM wrapper may also respond in 1 cycle.
- State machine:
  - FETCH: rd=1, addr=PC, byte_select=4'b1111. On ready, latch IR and go to EXECUTE.
  - EXECUTE (1 cycle):
    - Decode and ALU op.
    - Branch comparison; the target is PC+immB.
    - JAL: PC+immJ. JALR: (rs1+immI) & ~1.
    - LUI and AUIPC.
    - Loads and stores go to MEM. All others write rd and the next PC, then go to FETCH.
  - MEM:
    - Load: rd=1, addr=rs1+immI.
    - Store: wr=1, addr=rs1+immS.
    - On ready: a load writes rd, then PC+=4 and go to FETCH.
  - TRAP: terminal. trap_o=1, no bus requests, PC frozen until reset.
- Lanes, for byte address a:
  - Byte access: byte_select = 4'b0001<<a[1:0]; store data = the byte replicated ×4.
  - Halfword: byte_select = 4'b0011<<a[1:0]; data = the halfword replicated ×2.
  - Word: byte_select = 4'b1111.
  - Loads extract the selected lane(s) from the read word. LB/LH sign-extend; LBU/LHU zero-extend.
- Exceptions (enter TRAP without side effects):
  - Illegal opcode or funct field.
  - ECALL or EBREAK.
  - Misaligned halfword/word load or store (detected in EXECUTE, before any bus request).
  - Taken branch or jump target with bits [1:0] ≠ 0.
  - FENCE executes as a NOP.
- Arithmetic:
  - Wraps modulo 2^32.
  - Shifts use rs2[4:0] or shamt.
  - SLT/SLTI are signed; SLTU/SLTIU are unsigned.
  - SRA/SRAI are arithmetic.

Test Plan:
- Reset: hold rst_i=0 for 5 cycles -> trap_o=0, rd=0, wr=0. After release, the first rd=1 has addr=0x0 and byte_select=4'hF.
- ALU chain: addi x1,x0,5; addi x2,x1,-7; sltu x3,x1,x2; sra x4,x2,x1 -> x2=0xFFFFFFFE, x3=1, x4=0xFFFFFFFF.
- Byte store/load:
  - x5=0x80 and x6=0x100. sb x5,3(x6) -> wr=1, addr=0x103, byte_select=4'b1000, data_o=0x80808080.
  - lb x7,3(x6) -> x7=0xFFFFFF80. lbu -> 0x00000080.
- Branch/jump: beq taken to PC+8 and jal x1,+12 -> fetch addresses follow the targets; x1 = jal PC+4.
- Wait states: hold ready=0 for 3 cycles during a fetch -> addr/rd stable throughout; the instruction executes only after ready=1.
- Trap:
  - Fetch of 0x00000000 (illegal) -> trap_o=1 next cycle and stays 1; no further rd/wr.
  - lw at address 0x102 -> trap, no bus access.
